// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the 6-bit program counter and the
// shared instruction/data memory port. One instruction is in flight at a time.
// Optional build macro PC_SEQ_SINGLE_STEP_EN adds the `step` input and the
// PAUSE state, which holds after each instruction until a step pulse.
module pc_sequencer #(
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [3:0] OP_HALT     = 4'hF,
  parameter logic [3:0] OP_JMP      = 4'hE,
  parameter logic [3:0] OP_BRZ      = 4'hD,
  parameter logic [3:0] OP_LD       = 4'hC
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [5:0] imm,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       pc_ld,
  output logic [5:0] pc_target,
  output logic       ir_ld,
  output logic       mem_req,
  output logic       alu_en,
  output logic       reg_we,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
`ifdef PC_SEQ_SINGLE_STEP_EN
  ,
  input  logic       step
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;
  localparam logic [2:0] PAUSE  = 3'd7;

  // State entered once an instruction retires.
`ifdef PC_SEQ_SINGLE_STEP_EN
  localparam logic [2:0] RESUME = PAUSE;
`else
  localparam logic [2:0] RESUME = FETCH;
`endif

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int          CW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = CW'(ACK_TIMEOUT - 1);
  localparam bit          TO_EN = (ACK_TIMEOUT != 0);

  logic [2:0]    r_state;
  logic          r_fault;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_next;
  logic          w_wait;
  logic          w_expire;

  assign w_wait   = (r_state == FETCH) || (r_state == MEM);
  // An ack on the last allowed cycle wins over the timeout.
  assign w_expire = TO_EN && w_wait && !mem_ack && (r_cnt == LIM);

  assign state = r_state;
  assign fault = r_fault;

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = FETCH;
      FETCH:  if (mem_ack) w_next = DECODE;
              else if (w_expire) w_next = HALT;
      DECODE: w_next = (opcode == OP_HALT) ? HALT : EXEC;
      EXEC:   if ((opcode == OP_JMP) || (opcode == OP_BRZ)) w_next = RESUME;
              else if (opcode == OP_LD) w_next = MEM;
              else w_next = WB;
      MEM:    if (mem_ack) w_next = WB;
              else if (w_expire) w_next = HALT;
      WB:     w_next = RESUME;
      HALT:   w_next = HALT;
      default: begin
`ifdef PC_SEQ_SINGLE_STEP_EN
        if (step) w_next = FETCH;
`else
        w_next = IDLE;
`endif
      end
    endcase
  end

  // State and sticky fault registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_expire) r_fault <= 1'b1;
    end
  end

  // Ack wait counter: runs while waiting in FETCH/MEM, zero everywhere else,
  // so it is already clear whenever either wait state is entered.
  always_ff @(posedge clk) begin
    if (res) begin
      r_cnt <= '0;
    end else if (TO_EN && w_wait && !mem_ack && !w_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Strobes decoded from the current state and the live instruction fields.
  always_comb begin
    pc_en     = 1'b0;
    pc_ld     = 1'b0;
    pc_target = '0;
    ir_ld     = 1'b0;
    mem_req   = 1'b0;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        ir_ld   = mem_ack;
      end
      EXEC: begin
        alu_en = 1'b1;
        if ((opcode == OP_JMP) || ((opcode == OP_BRZ) && branch_taken)) begin
          pc_ld     = 1'b1;
          pc_target = imm;
        end else if (opcode == OP_BRZ) begin
          pc_en = 1'b1;
        end
      end
      MEM:  mem_req = 1'b1;
      WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that sequences the 6-bit program_counter and the instruction/data memory port.
- Drives PC increment/load, instruction-register load, ALU enable and register write-back.
- Sits between program_counter, instruction register, memory and register file; one instruction in flight at a time.

Parameters:
- ACK_TIMEOUT, 16, max cycles waiting for mem_ack in FETCH/MEM before fault; 0 disables the timeout.
- OP_HALT, 4'hF, halt opcode.
- OP_JMP, 4'hE, unconditional jump opcode.
- OP_BRZ, 4'hD, conditional branch opcode.
- OP_LD, 4'hC, memory load opcode; all other opcodes are ALU ops.

Ports:
- clk  input  1  clock, rising edge.
- res  input  1  synchronous active-high reset.
- start  input  1  begin execution from IDLE.
- opcode  input  4  opcode field of the instruction register.
- imm  input  6  jump/branch target field of the instruction register.
- branch_taken  input  1  branch condition (zero flag), sampled in EXEC.
- mem_ack  input  1  memory completion, one-cycle or held.
- pc_en  output  1  program_counter increment enable.
- pc_ld  output  1  program_counter parallel-load strobe.
- pc_target  output  6  load value, valid when pc_ld=1.
- ir_ld  output  1  instruction register load strobe.
- mem_req  output  1  memory request.
- alu_en  output  1  ALU operate strobe.
- reg_we  output  1  register file write enable.
- halted  output  1  sequencer in HALT.
- fault  output  1  sticky memory-timeout flag.
- state  output  3  current state encoding, for debug.

Behaviour:
- Interface: one clock (clk); reset res is synchronous, active-high.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, PAUSE=7 (PAUSE is used only with the optional feature).
- State and fault are registered. All other outputs are combinational from state, opcode, branch_taken and mem_ack.
- Reset: state=IDLE, fault=0, timeout counter=0. All strobes are 0 and pc_target=0 in IDLE.
- res has priority over every other input. Asserting res mid-handshake drops mem_req after the edge; a later stray mem_ack is ignored.
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH: mem_req=1.
  - If mem_ack=1: ir_ld=1 that cycle, then go to DECODE.
  - Otherwise stay in FETCH and increment the timeout counter.
- DECODE: one cycle, no strobes.
  - opcode==OP_HALT: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: alu_en=1 for exactly one cycle.
  - OP_JMP: pc_ld=1, pc_target=imm, then go to FETCH.
  - OP_BRZ with branch_taken=1: pc_ld=1, pc_target=imm, then go to FETCH.
  - OP_BRZ with branch_taken=0: pc_en=1, then go to FETCH.
  - OP_LD: go to MEM.
  - Any other opcode: go to WB.
- MEM: mem_req=1. Go to WB on mem_ack; timeout rules are the same as FETCH.
- WB: reg_we=1 and pc_en=1, then go to FETCH.
- HALT: halted=1, all strobes 0. start is ignored; only res exits HALT.
- Timeout counter:
  - Cleared on entering FETCH or MEM.
  - If the counter reaches ACK_TIMEOUT-1 with mem_ack=0, set fault=1 on that edge and go to HALT.
  - If mem_ack arrives on that same cycle, the ack wins and no fault is raised.
- Invariants:
  - pc_en and pc_ld are never both 1.
  - Each strobe asserts for at most one cycle per instruction, except mem_req, which holds until ack or timeout.
- Latency with immediate ack:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Jump/branch: 3 cycles.
  - Load: 5 cycles.
- PC wrap 63->0 is handled by program_counter; the sequencer does not track it.

Optional Feature:
- Macro: PC_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - WB, and the EXEC jump/branch paths, go to PAUSE instead of FETCH.
  - PAUSE has no strobes; it goes to FETCH on step=1.
  - A step pulse in any other state is ignored.
- Undefined: no step port, PAUSE is unreachable, and behaviour is as described above.

Test Plan:
- res 2 cycles, start=1, opcode=4'h1, mem_ack tied 1 -> state sequence 1,2,3,5,1; ir_ld in FETCH, alu_en in EXEC, reg_we and pc_en together in WB; pc_ld never asserts.
- opcode=4'hE, imm=6'h2A -> EXEC cycle has pc_ld=1, pc_target=6'h2A, pc_en=0; next state FETCH; 3 cycles per instruction.
- opcode=4'hD, branch_taken=0 then 1 -> first pass pc_en=1; second pass pc_ld=1 with pc_target=imm.
- opcode=4'hC, mem_ack raised 3 cycles after entering MEM -> mem_req high 4 cycles in MEM, then WB with reg_we=1; total 8 cycles.
- ACK_TIMEOUT=4, mem_ack held 0 in FETCH -> fault=1 and halted=1 after 4 FETCH cycles. Repeat with ack on the 4th cycle -> no fault.
- opcode=4'hF -> halted=1 after DECODE; start pulses have no effect; res=1 -> state=0 and fault=0 next cycle.
